// File: rtl/unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : unidad_control_multiciclo
//  Description : Multicycle control unit for the Proyecto datapath. Accepts
//                one 19-bit instruction via valid/ready and sequences
//                DECODE -> EXEC -> COMMIT, driving register-file addresses
//                and enables, ALU op select and data-memory write enable.
//                Optional performance counters are built only when the
//                macro CTRL_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidad_control_multiciclo #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [18:0]      instruccion,
    output logic [4:0]       rf_raddr_a,
    output logic [4:0]       rf_raddr_b,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [1:0]       alu_op,
    output logic             mem_we,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SW  = 4'b0111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_SLT   = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [18:0] instr_q, instr_d;

    // Fields of the captured word; the live input is never decoded after accept.
    logic [3:0] w_opcode;
    logic [4:0] w_rd, w_rs, w_rt;
    logic       w_legal;
    logic       w_is_sw;

    assign w_opcode = instr_q[18:15];
    assign w_rd     = instr_q[14:10];
    assign w_rs     = instr_q[9:5];
    assign w_rt     = instr_q[4:0];
    assign w_is_sw  = (w_opcode == OP_SW);
    assign w_legal  = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                      (w_opcode == OP_SLT) || w_is_sw;

    // State and instruction register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Next state: capture on handshake, illegal opcodes skip EXEC.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instruccion;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = w_legal ? S_EXEC : S_COMMIT;
            S_EXEC:   state_d = S_COMMIT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: addresses/alu_op held from DECODE through COMMIT, enables only in COMMIT.
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        rf_raddr_a  = '0;
        rf_raddr_b  = '0;
        rf_waddr    = '0;
        alu_op      = ALU_ADD;
        rf_we       = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        if (state_q != S_IDLE) begin
            rf_raddr_a = w_rs;
            rf_raddr_b = w_rt;
            rf_waddr   = w_rd;
            case (w_opcode)
                OP_SUB:  alu_op = ALU_SUB;
                OP_SLT:  alu_op = ALU_SLT;
                OP_SW:   alu_op = ALU_PASSB;
                default: alu_op = ALU_ADD;
            endcase
        end
        if (state_q == S_COMMIT) begin
            done = 1'b1;
            if (!w_legal) begin
                illegal = 1'b1;
            end else if (w_is_sw) begin
                mem_we = 1'b1;
            end else begin
                rf_we = 1'b1;
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    // Counter increments; natural wrap at 2^CNT_W.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (done && !illegal) retired_cnt_d = retired_cnt_q + 1'b1;
        if (done && illegal)  illegal_cnt_d = illegal_cnt_q + 1'b1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`else
    assign retired_cnt = '0;
    assign illegal_cnt = '0;
`endif

endmodule
`default_nettype wire
